qsys_sc_tei0026_usr_in_debounce: RTL and testbench

Per-channel input conditioner for the user push-buttons/switches, sitting directly upstream of the user input PIO and driving its `in_port`. It synchronises each raw asynchronous pin into the `clk` domain, filters out contact bounce with a per-channel stability counter, and presents clean levels plus one-cycle rise/fall event pulses. The PIO samples `clean_out` through its address-0 read path. The event pulses are available for edge-capture or interrupt logic.

---
 rtl/qsys_sc_tei0026_usr_in_debounce.sv | 114 +++++++++++
 tb/tb_qsys_sc_tei0026_usr_in_debounce.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_sc_tei0026_usr_in_debounce.sv
// qsys_sc_tei0026_usr_in_debounce
// Per-channel conditioner for user buttons/switches ahead of the user-input PIO.
// Each raw pin is synchronised through two flops. A per-channel stability
// counter then filters out contact bounce. The block outputs clean levels,
// one-cycle rise/fall pulses, and a combined "changed" strobe.
module qsys_sc_tei0026_usr_in_debounce #(
    parameter int WIDTH      = 3,
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    // Last count value before a new level is accepted. With DEB_CYCLES == 1
    // this is zero, so any difference is accepted on the first filter cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LEVEL}};

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;

    // Two-flop synchroniser for the asynchronous pin levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= INIT_VEC;
            s2_q <= INIT_VEC;
        end else begin
            s1_q <= raw_in;
            s2_q <= s1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             clean_nx;
            logic             rise_nx;
            logic             fall_nx;

            // Stability filter: count while the synchronised level differs
            // from the accepted level, and accept it once the count reaches
            // the last value. Any agreement restarts the count from zero.
            always_comb begin
                cnt_d    = '0;
                clean_nx = clean_q[gi];
                rise_nx  = 1'b0;
                fall_nx  = 1'b0;
                if (s2_q[gi] != clean_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        clean_nx = s2_q[gi];
                        rise_nx  = s2_q[gi];
                        fall_nx  = ~s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Per-channel stability counter register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign clean_d[gi] = clean_nx;
            assign rise_d[gi]  = rise_nx;
            assign fall_d[gi]  = fall_nx;
        end
    endgenerate

    // Any accepted edge on any channel produces one shared strobe.
    assign changed_d = |(rise_d | fall_d);

    // Registered clean levels and event pulses. Pulses last exactly one cycle
    // because the next-state terms are recomputed every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_q   <= INIT_VEC;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_qsys_sc_tei0026_usr_in_debounce.sv
// Testbench for qsys_sc_tei0026_usr_in_debounce (DEB_CYCLES = 4, INIT_LEVEL = 0).
// A history-based reference model accepts a new level when the last DEB
// synchronised samples since the previous acceptance all differ from the
// current clean level.
module tb_qsys_sc_tei0026_usr_in_debounce;

    localparam int W    = 3;
    localparam int DEB  = 4;
    localparam int CW   = 18;
    localparam bit INIT = 1'b0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         changed;

    int tests_run = 0;
    int failures  = 0;

    qsys_sc_tei0026_usr_in_debounce #(
        .WIDTH     (W),
        .DEB_CYCLES(DEB),
        .CNT_W     (CW),
        .INIT_LEVEL(INIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] hist[$];      // raw_in sampled at each edge since reset
    int           m_k;          // edges since reset
    int           m_last[W];    // edge index of last acceptance per channel
    logic [W-1:0] m_clean;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_changed;

    // Level the filter sees at edge j: raw sampled two edges earlier.
    function automatic logic [W-1:0] s2_at(int j);
        if (j >= 2) return hist[j-2];
        return {W{INIT}};
    endfunction

    function automatic logic accepts(int c, int kk, int la, logic cur);
        int streak = 0;
        for (int j = kk; j > la && j >= 0 && streak < DEB; j--) begin
            logic [W-1:0] s;
            s = s2_at(j);
            if (s[c] == cur) break;
            streak++;
        end
        return streak == DEB;
    endfunction

    function automatic logic [W-1:0] acc_vec(int kk);
        logic [W-1:0] a = '0;
        for (int c = 0; c < W; c++) a[c] = accepts(c, kk, m_last[c], m_clean[c]);
        return a;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            m_k       <= 0;
            for (int c = 0; c < W; c++) m_last[c] <= -1;
            m_clean   <= {W{INIT}};
            m_rise    <= '0;
            m_fall    <= '0;
            m_changed <= 1'b0;
        end else begin
            m_rise    <= acc_vec(m_k) & ~m_clean;
            m_fall    <= acc_vec(m_k) & m_clean;
            m_clean   <= m_clean ^ acc_vec(m_k);
            m_changed <= |acc_vec(m_k);
            for (int c = 0; c < W; c++)
                if (accepts(c, m_k, m_last[c], m_clean[c])) m_last[c] <= m_k;
            hist.push_back(raw_in);
            m_k <= m_k + 1;
        end
    end

    // Drive a level and let everything settle.
    task automatic settle(input logic [W-1:0] v);
        raw_in = v;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        raw_in  = 3'b111;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({clean_out, rise_pulse, fall_pulse, changed} !== 10'b0) begin
            failures++;
            $display("FAIL reset_state got=%b required=%b", {clean_out, rise_pulse, fall_pulse, changed}, 10'b0);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests_run++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
                failures++;
                $display("FAIL reset_model n=%0d got=%b exp=%b", n,
                         {clean_out, rise_pulse, fall_pulse, changed}, {m_clean, m_rise, m_fall, m_changed});
            end
            tests_run++;
            if (rise_pulse !== (n == 6 ? 3'b111 : 3'b000) || changed !== (n == 6) ||
                clean_out !== (n >= 6 ? 3'b111 : 3'b000)) begin
                failures++;
                $display("FAIL reset_release n=%0d clean=%b rise=%b chg=%b required clean=%b rise=%b chg=%b", n,
                         clean_out, rise_pulse, changed, (n >= 6 ? 3'b111 : 3'b000),
                         (n == 6 ? 3'b111 : 3'b000), (n == 6));
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_step();
        settle(3'b000);
        raw_in = 3'b001;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests_run++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
                failures++;
                $display("FAIL step_model n=%0d got=%b exp=%b", n,
                         {clean_out, rise_pulse, fall_pulse, changed}, {m_clean, m_rise, m_fall, m_changed});
            end
            tests_run++;
            if (rise_pulse !== (n == 6 ? 3'b001 : 3'b000) || clean_out !== (n >= 6 ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL step_timing n=%0d clean=%b rise=%b required clean=%b rise=%b", n,
                         clean_out, rise_pulse, (n >= 6 ? 3'b001 : 3'b000), (n == 6 ? 3'b001 : 3'b000));
            end
        end
        $display("[TB] test_clean_step done");
    endtask

    task automatic test_bounce();
        settle(3'b001);
        for (int i = 0; i < 42; i++) begin
            raw_in[1] = ((i / 3) % 2 == 0);
            @(negedge clk);
            tests_run++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
                failures++;
                $display("FAIL bounce_model i=%0d got=%b exp=%b", i,
                         {clean_out, rise_pulse, fall_pulse, changed}, {m_clean, m_rise, m_fall, m_changed});
            end
            tests_run++;
            if ((rise_pulse | fall_pulse) !== 3'b000 || clean_out !== 3'b001) begin
                failures++;
                $display("FAIL bounce_leak i=%0d clean=%b rise=%b fall=%b required clean=001 no pulses", i,
                         clean_out, rise_pulse, fall_pulse);
            end
        end
        raw_in[1] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests_run++;
            if (rise_pulse !== (n == 6 ? 3'b010 : 3'b000) || fall_pulse !== 3'b000) begin
                failures++;
                $display("FAIL bounce_accept n=%0d rise=%b fall=%b required rise=%b fall=000", n,
                         rise_pulse, fall_pulse, (n == 6 ? 3'b010 : 3'b000));
            end
        end
        $display("[TB] test_bounce done");
    endtask

    task automatic test_mixed();
        settle(3'b101);
        raw_in = 3'b010;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests_run++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !==
                {(n >= 6 ? 3'b010 : 3'b101), (n == 6 ? 3'b010 : 3'b000), (n == 6 ? 3'b101 : 3'b000), (n == 6)}) begin
                failures++;
                $display("FAIL mixed n=%0d got=%b required=%b", n, {clean_out, rise_pulse, fall_pulse, changed},
                         {(n >= 6 ? 3'b010 : 3'b101), (n == 6 ? 3'b010 : 3'b000), (n == 6 ? 3'b101 : 3'b000), (n == 6)});
            end
        end
        $display("[TB] test_mixed done");
    endtask

    task automatic test_reset_mid();
        // Reset is asynchronous: clean_out must drop without waiting for an edge.
        settle(3'b111);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({clean_out, rise_pulse, fall_pulse, changed} !== 10'b0) begin
            failures++;
            $display("FAIL async_reset got=%b required=%b", {clean_out, rise_pulse, fall_pulse, changed}, 10'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        settle(3'b000);
        raw_in = 3'b100;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({clean_out, rise_pulse, fall_pulse, changed} !== 10'b0) begin
            failures++;
            $display("FAIL mid_reset_state got=%b required=%b", {clean_out, rise_pulse, fall_pulse, changed}, 10'b0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests_run++;
            if (rise_pulse !== (n == 6 ? 3'b100 : 3'b000) || clean_out !== (n >= 6 ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL mid_reset_release n=%0d clean=%b rise=%b required clean=%b rise=%b", n,
                         clean_out, rise_pulse, (n >= 6 ? 3'b100 : 3'b000), (n == 6 ? 3'b100 : 3'b000));
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_glitch();
        int rises;
        int falls;
        settle(3'b000);
        // High for DEB-1 samples: must be rejected.
        rises = 0;
        falls = 0;
        raw_in = 3'b001;
        repeat (DEB - 1) @(negedge clk);
        raw_in = 3'b000;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rises += int'(rise_pulse[0]);
            falls += int'(fall_pulse[0]);
        end
        tests_run++;
        if (rises != 0 || falls != 0 || clean_out !== 3'b000) begin
            failures++;
            $display("FAIL glitch_short rises=%0d falls=%0d clean=%b required 0 0 000", rises, falls, clean_out);
        end
        // High for exactly DEB samples: accepted once, then released again.
        rises = 0;
        falls = 0;
        raw_in = 3'b001;
        repeat (DEB) @(negedge clk);
        raw_in = 3'b000;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            rises += int'(rise_pulse[0]);
            falls += int'(fall_pulse[0]);
        end
        tests_run++;
        if (rises != 1 || falls != 1) begin
            failures++;
            $display("FAIL glitch_exact rises=%0d falls=%0d required 1 1", rises, falls);
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_random();
        int run_left[W];
        int events = 0;
        for (int c = 0; c < W; c++) run_left[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < W; c++) begin
                if (run_left[c] == 0) begin
                    raw_in[c]   = 1'($urandom_range(0, 1));
                    run_left[c] = int'($urandom_range(1, 8));
                end
                run_left[c]--;
            end
            reset_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            if (changed === 1'b1) events++;
            tests_run++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
                failures++;
                $display("FAIL random_model i=%0d raw=%b got=%b exp=%b", i, raw_in,
                         {clean_out, rise_pulse, fall_pulse, changed}, {m_clean, m_rise, m_fall, m_changed});
            end
        end
        reset_n = 1'b1;
        $display("[TB] test_random done, %0d change events", events);
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_mixed();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
